// File: rtl/reg_file.sv
// reg_file: architectural register file feeding the ALU.
//
// Purpose:
//   2**ADDR_W x DATA_W storage with entry 0 hardwired to zero.
//   Two combinational operand read ports, one debug read port, and one clocked write port.
//   A counter tracks committed writes.
//
// Ports:
//   clk_i     clock; all state updates on the rising edge
//   rst_i     synchronous active-high reset (clears all entries and the counter)
//   ra0_i     read address, port 0 (ALU src0)
//   ra1_i     read address, port 1 (ALU src1)
//   rd0_o     read data, port 0, combinational
//   rd1_o     read data, port 1, combinational
//   we_i      write enable
//   wa_i      write address
//   wd_i      write data
//   dbg_ra_i  debug read address
//   dbg_rd_o  debug read data, combinational
//   wr_cnt_o  committed-write count, registered, wraps modulo 2**CNT_W

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ra0_i,
    input  logic [ADDR_W-1:0] ra1_i,
    output logic [DATA_W-1:0] rd0_o,
    output logic [DATA_W-1:0] rd1_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [ADDR_W-1:0] dbg_ra_i,
    output logic [DATA_W-1:0] dbg_rd_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d;
    logic              commit;

    // Writes to entry 0 are dropped entirely, so they neither change state nor count.
    // With we_i low, the AND keeps X on wa_i away from the state.
    assign commit   = we_i && (wa_i != '0);
    assign wr_cnt_d = wr_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else if (commit) begin
            mem_q[wa_i] <= wd_i;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // Reads come straight from storage with no write bypass.
    // wd_i is a combinational function of rd0_o/rd1_o through the ALU, so a bypass would close a loop.
    assign rd0_o    = (ra0_i    == '0) ? '0 : mem_q[ra0_i];
    assign rd1_o    = (ra1_i    == '0) ? '0 : mem_q[ra1_i];
    assign dbg_rd_o = (dbg_ra_i == '0) ? '0 : mem_q[dbg_ra_i];
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file with a queue-based scoreboard.
//
// Stimulus is applied 1 ns after each rising edge.
// Each expectation is pushed into a queue at the same time.
// A monitor on the falling edge pops every pending expectation and compares it with the live outputs.
// A second instance built with CNT_W=4 shares all inputs and covers counter wrap.

module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum int {K_RD0, K_RD1, K_DBG, K_CNT, K_CNT4, K_DBG4, K_ALU} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ra0, ra1, wa, dbg_ra;
    logic              we;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd0, rd1, dbg_rd;
    logic [DATA_W-1:0] rd0_4, rd1_4, dbg_rd_4;
    logic [31:0]       wr_cnt;
    logic [3:0]        wr_cnt_4;

    exp_t scb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .ra0_i(ra0), .ra1_i(ra1), .rd0_o(rd0), .rd1_o(rd1),
        .we_i(we), .wa_i(wa), .wd_i(wd), .dbg_ra_i(dbg_ra), .dbg_rd_o(dbg_rd), .wr_cnt_o(wr_cnt)
    );

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .ra0_i(ra0), .ra1_i(ra1), .rd0_o(rd0_4), .rd1_o(rd1_4),
        .we_i(we), .wa_i(wa), .wd_i(wd), .dbg_ra_i(dbg_ra), .dbg_rd_o(dbg_rd_4), .wr_cnt_o(wr_cnt_4)
    );

    task automatic expect_val(input kind_t k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        scb_q.push_back(e);
    endtask

    // Waits for the next rising edge, then drives one cycle of inputs.
    task automatic cycle(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] r0,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] dra);
        @(posedge clk);
        #1;
        rst = r; we = w; wa = a; wd = d; ra0 = r0; ra1 = r1; dbg_ra = dra;
    endtask

    // Monitor: the outputs are presented every cycle, so compare whatever is pending on each falling edge.
    always @(negedge clk) begin
        while (scb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = scb_q.pop_front();
            case (e.kind)
                K_RD0:   act = rd0;
                K_RD1:   act = rd1;
                K_DBG:   act = dbg_rd;
                K_CNT:   act = wr_cnt;
                K_CNT4:  act = {28'd0, wr_cnt_4};
                K_DBG4:  act = dbg_rd_4;
                default: act = rd0 - rd1;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0; dbg_ra = '0;
        cycle(1, 0, 0, 0, 0, 0, 0);

        // Post-reset state
        cycle(0, 0, 0, 0, 5, 31, 0);
        expect_val(K_RD0, 32'h0, "reset_rd0_r5");
        expect_val(K_RD1, 32'h0, "reset_rd1_r31");
        expect_val(K_DBG, 32'h0, "reset_dbg_r0");
        expect_val(K_CNT, 32'h0, "reset_cnt");
        expect_val(K_CNT4, 32'h0, "reset_cnt4");

        // Reset clear: write r5, then reset
        cycle(0, 1, 5, 32'hDEADBEEF, 5, 0, 5);
        expect_val(K_RD0, 32'h0, "r5_old_during_write");
        cycle(1, 0, 0, 0, 5, 0, 5);
        expect_val(K_RD0, 32'hDEADBEEF, "r5_written");
        expect_val(K_CNT, 32'd1, "cnt_after_r5");
        cycle(0, 0, 0, 0, 5, 0, 5);
        expect_val(K_RD0, 32'h0, "r5_cleared_by_reset");
        expect_val(K_CNT, 32'd0, "cnt_cleared_by_reset");

        // Basic write/read
        cycle(0, 1, 3, 32'h7, 0, 0, 0);
        cycle(0, 1, 4, 32'h2, 3, 0, 0);
        expect_val(K_RD0, 32'h7, "r3_read");
        cycle(0, 0, 0, 0, 3, 4, 4);
        expect_val(K_RD0, 32'h7, "src0_r3");
        expect_val(K_RD1, 32'h2, "src1_r4");
        expect_val(K_DBG, 32'h2, "dbg_r4");
        expect_val(K_ALU, 32'h5, "alu_sub_operands");
        expect_val(K_CNT, 32'd2, "cnt_two_writes");

        // Register 0 ignores writes and does not count
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        expect_val(K_RD0, 32'h0, "r0_reads_zero");
        expect_val(K_DBG, 32'h0, "r0_dbg_zero");
        expect_val(K_CNT, 32'd2, "r0_write_not_counted");

        // Read during write returns the old value
        cycle(0, 1, 7, 32'h11, 0, 0, 0);
        cycle(0, 1, 7, 32'h22, 7, 7, 0);
        expect_val(K_RD0, 32'h11, "rdw_rd0_old");
        expect_val(K_RD1, 32'h11, "rdw_rd1_old");
        cycle(0, 0, 0, 0, 7, 7, 7);
        expect_val(K_RD0, 32'h22, "rdw_rd0_new");
        expect_val(K_RD1, 32'h22, "rdw_rd1_new");
        expect_val(K_CNT, 32'd4, "cnt_same_reg_counts");

        // A write in the reset cycle is discarded
        cycle(1, 1, 9, 32'h55, 0, 0, 0);
        cycle(0, 0, 0, 0, 7, 9, 9);
        expect_val(K_DBG, 32'h0, "r9_write_in_reset_lost");
        expect_val(K_RD0, 32'h0, "r7_cleared");
        expect_val(K_CNT, 32'd0, "cnt_reset_over_write");
        expect_val(K_CNT4, 32'd0, "cnt4_reset_over_write");

        // Counter wrap on the 4-bit build: 17 committed writes give 17 mod 16 = 1
        for (int i = 0; i < 17; i++) begin
            cycle(0, 1, ADDR_W'(i + 1), 32'hA000_0000 + 32'(i), 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 1, 16, 17);
        expect_val(K_CNT4, 32'd1, "cnt4_wrap");
        expect_val(K_CNT, 32'd17, "cnt_17");
        expect_val(K_DBG, 32'hA000_0010, "dbg_last_write");
        expect_val(K_DBG4, 32'hA000_0010, "dbg4_last_write");
        expect_val(K_RD0, 32'hA000_0000, "wrap_r1");
        expect_val(K_RD1, 32'hA000_000F, "wrap_r16");

        // Writes with we low do not disturb state
        cycle(0, 0, 1, 32'h1234_5678, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        expect_val(K_RD0, 32'hA000_0000, "we_low_no_write");
        expect_val(K_CNT, 32'd17, "we_low_no_count");

        @(posedge clk);
        @(posedge clk);
        if (scb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", scb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
